// File: rtl/regfile_req_ctrl.sv
// Request sequencer in front of the 4x16 register file: in-order request FIFO,
// registered rf_* strobes, and a single-entry read response port.
module regfile_req_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_wr_i,
   input  logic [ADDR_W-1:0]           req_addr_i,
   input  logic [DATA_W-1:0]           req_wdata_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [ADDR_W-1:0]           rsp_addr_o,
   output logic [DATA_W-1:0]           rsp_rdata_o,
   output logic                        rf_sel_o,
   output logic                        rf_wr_o,
   output logic [ADDR_W-1:0]           rf_addr_o,
   output logic [DATA_W-1:0]           rf_wdata_o,
   input  logic [DATA_W-1:0]           rf_rdata_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
   output logic                        busy_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   req_t          fifo_mem [FIFO_DEPTH];
   req_t          head;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full, empty, push, pop, load;

   state_t            state_q, state_d;
   logic              rf_sel_q, rf_sel_d, rf_wr_q, rf_wr_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d, rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d, rsp_rdata_q, rsp_rdata_d;
   logic              rsp_valid_q, rsp_valid_d;

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign push  = req_valid_i && !full;
   assign head  = fifo_mem[rptr_q];

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wptr_q] <= '{wr: req_wr_i, addr: req_addr_i, wdata: req_wdata_i};
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      load        = 1'b0;
      rf_sel_d    = 1'b0;
      rf_wr_d     = rf_wr_q;
      rf_addr_d   = rf_addr_q;
      rf_wdata_d  = rf_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (rf_wr_q) begin
               if (!empty) load = 1'b1;
               else        state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // File registered its read data at the previous edge.
            rsp_valid_d = 1'b1;
            rsp_addr_d  = rf_addr_q;
            rsp_rdata_d = rf_rdata_i;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               if (!empty) begin
                  load    = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         pop        = 1'b1;
         rf_sel_d   = 1'b1;
         rf_wr_d    = head.wr;
         rf_addr_d  = head.addr;
         rf_wdata_d = head.wdata;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         rf_sel_q    <= 1'b0;
         rf_wr_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_wdata_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q     <= count_d;
         state_q     <= state_d;
         rf_sel_q    <= rf_sel_d;
         rf_wr_q     <= rf_wr_d;
         rf_addr_q   <= rf_addr_d;
         rf_wdata_q  <= rf_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready_o  = !full;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_addr_o   = rsp_addr_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rf_sel_o     = rf_sel_q;
   assign rf_wr_o      = rf_wr_q;
   assign rf_addr_o    = rf_addr_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign fifo_count_o = count_q;
   assign busy_o       = !empty || (state_q != IDLE);

endmodule
